// File: rtl/mmu_paged_pkg.sv
// mmu_pkg: register map, control-bit positions and Q/E phase encoding shared by the
// paged MMU files.
package mmu_pkg;
    localparam logic [15:0] REG_CTL   = 16'hFF90;
    localparam logic [15:0] REG_TASK  = 16'hFF91;
    localparam logic [15:0] REG_SAVED = 16'hFF92;
    localparam logic [15:0] MAP_BASE  = 16'hFFA0;
    localparam logic [15:0] MAP_TOP   = 16'hFFBF;
    localparam int CTL_WPF = 7;
    localparam int CTL_EN  = 6;
    localparam logic [1:0] PH_I  = 2'b00;
    localparam logic [1:0] PH_Q  = 2'b10;
    localparam logic [1:0] PH_QE = 2'b11;
    localparam logic [1:0] PH_E  = 2'b01;
endpackage

// File: rtl/mmu_paged_if.sv
// mmu_paged_if: CPU-side bus and memory-decode signals of the paged MMU.
interface mmu_paged_if #(parameter int PA_WIDTH = 6);
    logic                MRDY;
    logic [15:0]         ADDR;
    logic [7:0]          DIN;
    logic                BA;
    logic                BS;
    logic                RnW;
    logic                QX;
    logic                EX;
    logic [PA_WIDTH-1:0] QA;
    logic                nRD;
    logic                nWR;
    logic [7:0]          DOUT;
    logic                DOE;
    logic                WPFAULT;
    modport slave (input MRDY, ADDR, DIN, BA, BS, RnW,
                   output QX, EX, QA, nRD, nWR, DOUT, DOE, WPFAULT);
    modport master (output MRDY, ADDR, DIN, BA, BS, RnW,
                    input QX, EX, QA, nRD, nWR, DOUT, DOE, WPFAULT);
endinterface

// File: rtl/mmu_phase_gen.sv
// mmu_phase_gen: Q/E generation from CLKX4 as a 4-state {QX,EX} FSM, with E held
// high while MRDY is low; efall marks the CLKX4 edge that leaves E.
module mmu_phase_gen
    import mmu_pkg::*;
(
    input  logic CLKX4,
    input  logic nRESET,
    input  logic MRDY,
    output logic QX,
    output logic EX,
    output logic efall
);
    logic [1:0] state_q, state_d;

    always_comb begin
        state_d = state_q == PH_I  ? PH_Q :
                  state_q == PH_Q  ? PH_QE :
                  state_q == PH_QE ? PH_E :
                  (MRDY ? PH_I : PH_E);
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) state_q <= PH_I;
        else         state_q <= state_d;
    end

    assign QX    = state_q[1];
    assign EX    = state_q[0];
    assign efall = (state_q == PH_E) && MRDY;
endmodule

// File: rtl/mmu_paged.sv
// mmu_paged: per-task page translation with write protection, vector-fetch task
// switch and register readback; all register state commits on the edge leaving E.
module mmu_paged
    import mmu_pkg::*;
#(
    parameter int PAGE_BITS = 3,
    parameter int TASK_BITS = 1,
    parameter int PA_WIDTH  = 6
) (
    input  logic       CLKX4,
    input  logic       nRESET,
    mmu_paged_if.slave bus
);
    localparam int IW = TASK_BITS + PAGE_BITS;
    localparam int N  = 1 << IW;

    logic                 efall, ex;
    logic                 enmmu_q, enmmu_d, wpfault_q, wpfault_d, vec_prev_q, vec_prev_d;
    logic [1:0]           rommap_q, rommap_d;
    logic [TASK_BITS-1:0] task_q, task_d, saved_q, saved_d;
    logic [PA_WIDTH-1:0]  pa_q [N];
    logic [PA_WIDTH-1:0]  pa_d [N];
    logic [N-1:0]         wp_q, wp_d;
    logic [PAGE_BITS-1:0] page;
    logic [IW-1:0]        sel, map_idx;
    logic                 top_pg, hit_ctl, hit_task, hit_saved, in_win, map_ok;
    logic                 block, wr, vec, vfetch;
    logic [7:0]           rd_data, ctl_rd;

    mmu_phase_gen u_phase (
        .CLKX4 (CLKX4),
        .nRESET(nRESET),
        .MRDY  (bus.MRDY),
        .QX    (bus.QX),
        .EX    (ex),
        .efall (efall)
    );

    assign bus.EX    = ex;
    assign page      = bus.ADDR[15 -: PAGE_BITS];
    assign sel       = {task_q, page};
    assign top_pg    = bus.ADDR[15:8] == 8'hFF;
    assign hit_ctl   = bus.ADDR == REG_CTL;
    assign hit_task  = bus.ADDR == REG_TASK;
    assign hit_saved = bus.ADDR == REG_SAVED;
    assign in_win    = bus.ADDR >= MAP_BASE && bus.ADDR <= MAP_TOP;
    assign map_ok    = in_win && (32'(bus.ADDR[4:0]) < N);
    assign map_idx   = bus.ADDR[IW-1:0];
    assign block     = enmmu_q && wp_q[sel] && !top_pg;
    assign wr        = efall && !bus.RnW;
    assign vec       = !bus.BA && bus.BS;
    assign vfetch    = efall && vec && !vec_prev_q;

    assign bus.QA  = top_pg ? '1 : enmmu_q ? pa_q[sel] : PA_WIDTH'(page);
    assign bus.nRD = !(ex && bus.RnW);
    assign bus.nWR = !(ex && !bus.RnW && !block);
    assign bus.DOE = ex && bus.RnW && (hit_ctl || hit_task || hit_saved || in_win);
    assign bus.DOUT    = bus.DOE ? rd_data : 8'h00;
    assign bus.WPFAULT = wpfault_q;

    always_comb begin
        ctl_rd  = 8'(rommap_q) | (8'(wpfault_q) << CTL_WPF) | (8'(enmmu_q) << CTL_EN);
        rd_data = hit_ctl   ? ctl_rd :
                  hit_task  ? 8'(task_q) :
                  hit_saved ? 8'(saved_q) :
                  map_ok    ? (8'(pa_q[map_idx]) | {wp_q[map_idx], 7'b0}) : 8'h00;
    end

    // Vector fetch overrides any same-cycle TASK/SAVED write.
    always_comb begin
        enmmu_d    = wr && hit_ctl ? bus.DIN[CTL_EN] : enmmu_q;
        rommap_d   = wr && hit_ctl ? bus.DIN[1:0] : rommap_q;
        wpfault_d  = wr && hit_ctl ? 1'b0 : (wr && block) ? 1'b1 : wpfault_q;
        task_d     = vfetch ? '0 : (wr && hit_task) ? bus.DIN[TASK_BITS-1:0] : task_q;
        saved_d    = vfetch ? task_q : (wr && hit_saved) ? bus.DIN[TASK_BITS-1:0] : saved_q;
        vec_prev_d = efall ? vec : vec_prev_q;
        for (int i = 0; i < N; i++) begin
            pa_d[i] = (wr && map_ok && map_idx == IW'(i)) ? bus.DIN[PA_WIDTH-1:0] : pa_q[i];
            wp_d[i] = (wr && map_ok && map_idx == IW'(i)) ? bus.DIN[7] : wp_q[i];
        end
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            enmmu_q    <= 1'b0;
            rommap_q   <= 2'b00;
            wpfault_q  <= 1'b0;
            task_q     <= '0;
            saved_q    <= '0;
            vec_prev_q <= 1'b0;
            wp_q       <= '0;
            for (int i = 0; i < N; i++) pa_q[i] <= PA_WIDTH'(i % (1 << PAGE_BITS));
        end else begin
            enmmu_q    <= enmmu_d;
            rommap_q   <= rommap_d;
            wpfault_q  <= wpfault_d;
            task_q     <= task_d;
            saved_q    <= saved_d;
            vec_prev_q <= vec_prev_d;
            wp_q       <= wp_d;
            for (int i = 0; i < N; i++) pa_q[i] <= pa_d[i];
        end
    end
endmodule

// File: tb/tb_mmu_paged.sv
// tb_mmu_paged: directed scenarios plus randomized bus cycles, each checked against
// a behavioural model of the register map and translation rules.
module tb_mmu_paged;
    logic CLKX4 = 1'b0;
    logic nRESET = 1'b0;
    int checks = 0;
    int errors = 0;

    mmu_paged_if #(.PA_WIDTH(6)) bus ();
    mmu_paged #(.PAGE_BITS(3), .TASK_BITS(1), .PA_WIDTH(6)) dut (
        .CLKX4 (CLKX4),
        .nRESET(nRESET),
        .bus   (bus)
    );

    always #5 CLKX4 = ~CLKX4;

    int m_pa [16];
    bit m_wp [16];
    bit m_en, m_wpf, m_vprev;
    int m_rom, m_task, m_saved;

    int e_qa, e_dout, o_qa, o_dout;
    bit e_nrd, e_nwr, e_doe, e_wpf, o_nrd, o_nwr, o_doe, o_wpf;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pa[i] = i % 8;
            m_wp[i] = 0;
        end
        m_en = 0; m_wpf = 0; m_vprev = 0; m_rom = 0; m_task = 0; m_saved = 0;
    endtask

    function automatic int rd_val(input int a);
        if (a == 'hFF90) return (int'(m_wpf) << 7) | (int'(m_en) << 6) | m_rom;
        if (a == 'hFF91) return m_task;
        if (a == 'hFF92) return m_saved;
        if (a >= 'hFFA0 && a <= 'hFFBF && a - 'hFFA0 < 16)
            return (int'(m_wp[a - 'hFFA0]) << 7) | m_pa[a - 'hFFA0];
        return 0;
    endfunction

    // One full bus cycle: drive in I, sample in QE, return after E falls; model updated.
    task automatic cyc(input int a, input bit rnw, input int d, input bit ba, input bit bs,
                       input int extra);
        int pg, idx, old_task, left;
        bit top, blk, vec, readable, done;
        pg = a / 8192;
        top = a >= 'hFF00;
        idx = m_task * 8 + pg;
        e_qa = top ? 63 : (m_en ? m_pa[idx] : pg);
        blk = !rnw && m_en && m_wp[idx] && !top;
        e_nrd = !rnw;
        e_nwr = rnw || blk;
        readable = (a == 'hFF90) || (a == 'hFF91) || (a == 'hFF92) || (a >= 'hFFA0 && a <= 'hFFBF);
        e_doe = rnw && readable;
        e_dout = e_doe ? rd_val(a) : 0;
        e_wpf = m_wpf;
        done = 0;
        for (int t = 0; t < 12 && !done; t++) begin
            if (!bus.QX && !bus.EX) done = 1;
            else @(negedge CLKX4);
        end
        bus.ADDR = 16'(a); bus.RnW = rnw; bus.DIN = 8'(d); bus.BA = ba; bus.BS = bs; bus.MRDY = 1;
        done = 0;
        for (int t = 0; t < 12 && !done; t++) begin
            @(negedge CLKX4);
            done = bus.EX;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL cyc_wait_e: EX never rose at addr %h", a);
        end
        o_qa = int'(bus.QA); o_nrd = bus.nRD; o_nwr = bus.nWR;
        o_doe = bus.DOE; o_dout = int'(bus.DOUT); o_wpf = bus.WPFAULT;
        left = extra;
        done = 0;
        for (int t = 0; t < 30 && !done; t++) begin
            @(negedge CLKX4);
            if (!bus.EX) done = 1;
            else if (!bus.QX && left > 0) begin bus.MRDY = 0; left--; end
            else bus.MRDY = 1;
        end
        bus.MRDY = 1;
        if (!done) begin
            checks++; errors++;
            $display("FAIL cyc_wait_i: EX never fell at addr %h", a);
        end
        old_task = m_task;
        vec = !ba && bs;
        if (!rnw) begin
            if (a == 'hFF90) begin m_en = d[6]; m_rom = d & 3; m_wpf = 0; end
            else if (a == 'hFF91) m_task = d & 1;
            else if (a == 'hFF92) m_saved = d & 1;
            else if (a >= 'hFFA0 && a - 'hFFA0 < 16) begin
                m_pa[a - 'hFFA0] = d & 63;
                m_wp[a - 'hFFA0] = d[7];
            end
        end
        if (blk) m_wpf = 1;
        if (vec && !m_vprev) begin m_saved = old_task; m_task = 0; end
        m_vprev = vec;
    endtask

    task automatic test_reset();
        logic [1:0] seq [4];
        int run;
        int left;
        bit done;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        bus.MRDY = 1; bus.ADDR = 16'h0000; bus.DIN = 8'h00; bus.BA = 1; bus.BS = 0; bus.RnW = 1;
        nRESET = 0;
        repeat (3) @(negedge CLKX4);
        checks++;
        if ({bus.QX, bus.EX} !== 2'b00 || bus.WPFAULT !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: qx_ex=%b wpfault=%b, want 00 0", {bus.QX, bus.EX}, bus.WPFAULT);
        end
        nRESET = 1;
        model_reset();
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLKX4);
            checks++;
            if ({bus.QX, bus.EX} !== seq[i % 4]) begin
                errors++;
                $display("FAIL phase_seq[%0d]: got %b want %b", i, {bus.QX, bus.EX}, seq[i % 4]);
            end
        end
        done = 0;
        for (int t = 0; t < 10 && !done; t++) begin
            if (!bus.QX && !bus.EX) done = 1;
            else @(negedge CLKX4);
        end
        run = 0; left = 3; done = 0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge CLKX4);
            if (bus.EX) run++;
            else if (run > 0) done = 1;
            if (bus.EX && !bus.QX && left > 0) begin bus.MRDY = 0; left--; end
            else bus.MRDY = 1;
        end
        bus.MRDY = 1;
        checks++;
        if (run != 5) begin
            errors++;
            $display("FAIL mrdy_stretch: EX high %0d cycles, want 5", run);
        end
    endtask

    task automatic test_translate();
        cyc('hFF90, 0, 'h40, 1, 0, 0);
        cyc('hFFA2, 0, 'h05, 1, 0, 0);
        cyc('hFF91, 0, 'h00, 1, 0, 0);
        cyc('h4123, 1, 0, 1, 0, 0);
        checks++;
        if (o_qa != 'h05) begin errors++; $display("FAIL qa_mapped: got %h want 05", o_qa); end
        checks++;
        if (o_nrd !== 1'b0 || o_doe !== 1'b0) begin
            errors++; $display("FAIL read_strobe: nrd=%b doe=%b want 0 0", o_nrd, o_doe);
        end
        cyc('hFF90, 0, 'h00, 1, 0, 0);
        cyc('h4123, 1, 0, 1, 0, 1);
        checks++;
        if (o_qa != 'h02) begin errors++; $display("FAIL qa_identity: got %h want 02", o_qa); end
        cyc('hFF34, 1, 0, 1, 0, 0);
        checks++;
        if (o_qa != 'h3F) begin errors++; $display("FAIL qa_top_page: got %h want 3f", o_qa); end
    endtask

    task automatic test_write_protect();
        cyc('hFF90, 0, 'h40, 1, 0, 0);
        cyc('hFFAB, 0, 'h85, 1, 0, 0);
        cyc('hFF91, 0, 'h01, 1, 0, 0);
        cyc('h6000, 0, 'h11, 1, 0, 0);
        checks++;
        if (o_nwr !== 1'b1 || o_qa != 'h05) begin
            errors++; $display("FAIL wp_block: nwr=%b qa=%h want 1 05", o_nwr, o_qa);
        end
        cyc('hFF90, 1, 0, 1, 0, 0);
        checks++;
        if (o_wpf !== 1'b1 || o_dout != 'hC0 || o_doe !== 1'b1) begin
            errors++; $display("FAIL wp_fault: wpf=%b dout=%h doe=%b want 1 c0 1", o_wpf, o_dout, o_doe);
        end
        cyc('h4000, 0, 'h22, 1, 0, 0);
        checks++;
        if (o_nwr !== 1'b0) begin errors++; $display("FAIL wp_allow: nwr=%b want 0", o_nwr); end
        cyc('hFF90, 0, 'h40, 1, 0, 0);
        cyc('hFF90, 1, 0, 1, 0, 0);
        checks++;
        if (o_wpf !== 1'b0 || o_dout != 'h40) begin
            errors++; $display("FAIL wp_clear: wpf=%b dout=%h want 0 40", o_wpf, o_dout);
        end
    endtask

    task automatic test_vector();
        cyc('hFFF8, 1, 0, 0, 1, 0);
        cyc('hFFF9, 1, 0, 0, 1, 0);
        cyc('hFF91, 1, 0, 1, 0, 0);
        checks++;
        if (o_dout != 'h00 || o_doe !== 1'b1) begin
            errors++; $display("FAIL vec_task: dout=%h doe=%b want 00 1", o_dout, o_doe);
        end
        cyc('hFF92, 1, 0, 1, 0, 0);
        checks++;
        if (o_dout != 'h01 || o_doe !== 1'b1) begin
            errors++; $display("FAIL vec_saved: dout=%h doe=%b want 01 1", o_dout, o_doe);
        end
    endtask

    task automatic test_decode();
        cyc('hFF91, 1, 0, 1, 0, 0);
        checks++;
        if (o_doe !== 1'b1) begin errors++; $display("FAIL doe_ff91: got %b want 1", o_doe); end
        cyc('hFFA5, 1, 0, 1, 0, 0);
        checks++;
        if (o_doe !== 1'b1 || o_dout != 'h05) begin
            errors++; $display("FAIL doe_ffa5: doe=%b dout=%h want 1 05", o_doe, o_dout);
        end
        cyc('hFF80, 1, 0, 1, 0, 0);
        checks++;
        if (o_doe !== 1'b0 || o_dout != 0) begin
            errors++; $display("FAIL doe_ff80: doe=%b dout=%h want 0 00", o_doe, o_dout);
        end
        cyc('hFFB8, 0, 'hAA, 1, 0, 0);
        cyc('hFFB8, 1, 0, 1, 0, 0);
        checks++;
        if (o_doe !== 1'b1 || o_dout != 0) begin
            errors++; $display("FAIL oow_read: doe=%b dout=%h want 1 00", o_doe, o_dout);
        end
        cyc('hFFA8, 1, 0, 1, 0, 0);
        checks++;
        if (o_dout != 'h00) begin errors++; $display("FAIL oow_alias: dout=%h want 00", o_dout); end
    endtask

    task automatic test_random();
        int a, sel, vs;
        bit ba, bs;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            a = sel == 0 ? 'hFF90 : sel == 1 ? 'hFF91 : sel == 2 ? 'hFF92 :
                sel == 3 ? 'hFFA0 + $urandom_range(0, 31) :
                sel == 4 ? 'hFF80 + $urandom_range(0, 15) : $urandom_range(0, 'hFFFF);
            vs = $urandom_range(0, 4);
            ba = vs > 1;
            bs = vs == 0 || (vs > 1 && $urandom_range(0, 1) == 1);
            cyc(a, 1'($urandom_range(0, 1)), $urandom_range(0, 255), ba, bs, $urandom_range(0, 2));
            checks++;
            if (o_qa != e_qa || o_nrd !== e_nrd || o_nwr !== e_nwr || o_doe !== e_doe ||
                o_dout != e_dout || o_wpf !== e_wpf) begin
                errors++;
                $display("FAIL rand[%0d] addr=%h: qa=%h nrd=%b nwr=%b doe=%b dout=%h wpf=%b want %h %b %b %b %h %b",
                         n, a, o_qa, o_nrd, o_nwr, o_doe, o_dout, o_wpf,
                         e_qa, e_nrd, e_nwr, e_doe, e_dout, e_wpf);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit done;
        cyc('hFF90, 0, 'h40, 1, 0, 0);
        cyc('hFF91, 0, 'h01, 1, 0, 0);
        done = 0;
        for (int t = 0; t < 12 && !done; t++) begin
            @(negedge CLKX4);
            done = bus.QX && bus.EX;
        end
        nRESET = 0;
        #1;
        checks++;
        if (!done || {bus.QX, bus.EX} !== 2'b00) begin
            errors++; $display("FAIL reset_async: reached_qe=%b qx_ex=%b want 1 00", done, {bus.QX, bus.EX});
        end
        repeat (2) @(negedge CLKX4);
        nRESET = 1;
        model_reset();
        cyc('h4123, 1, 0, 1, 0, 0);
        checks++;
        if (o_qa != 'h02) begin errors++; $display("FAIL reset_qa: got %h want 02", o_qa); end
        cyc('hFF90, 1, 0, 1, 0, 0);
        checks++;
        if (o_dout != 0) begin errors++; $display("FAIL reset_ctl: got %h want 00", o_dout); end
        cyc('hFF91, 1, 0, 1, 0, 0);
        checks++;
        if (o_dout != 0) begin errors++; $display("FAIL reset_task: got %h want 00", o_dout); end
        cyc('hFFAB, 1, 0, 1, 0, 0);
        checks++;
        if (o_dout != 'h03) begin errors++; $display("FAIL reset_map: got %h want 03", o_dout); end
    endtask

    initial begin
        test_reset();
        test_translate();
        test_write_protect();
        test_vector();
        test_decode();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
